// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: widths, write-back select and load func3 codes.
// Also holds the W-stage register bundle used by the writer side of the regfile.
package pipeline_defs;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [1:0] WB_SEL_VALE = 2'b00;
  localparam logic [1:0] WB_SEL_VALM = 2'b01;
  localparam logic [1:0] WB_SEL_VALP = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   valE;
    logic [XLEN-1:0]   valM;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic [1:0]        sel;
    logic [2:0]        func3;
  } w_reg_t;

  localparam w_reg_t W_NOP = '0;
endpackage

// File: rtl/write_back_stage_if.sv
// M-to-W bundle, W register fields and regfile write port.
// instret is present only when WB_INSTRET_EN is defined.
interface write_back_stage_if;
  import pipeline_defs::*;

  logic              regW_i_stall;
  logic              regW_i_bubble;
  logic              memory_i_valid;
  logic [XLEN-1:0]   memory_i_pc;
  logic [XLEN-1:0]   memory_i_valE;
  logic [XLEN-1:0]   memory_i_valM;
  logic [REG_AW-1:0] memory_i_wb_rd;
  logic              memory_i_wb_reg_wen;
  logic [1:0]        memory_i_wb_valD_sel;
  logic [2:0]        memory_i_load_func3;

  logic              regW_o_valid;
  logic [XLEN-1:0]   regW_o_pc;
  logic [XLEN-1:0]   regW_o_valE;
  logic [XLEN-1:0]   regW_o_valM;
  logic [REG_AW-1:0] regW_o_wb_rd;
  logic              regW_o_wb_reg_wen;
  logic [1:0]        regW_o_wb_valD_sel;

  logic              write_back_o_reg_wen;
  logic [REG_AW-1:0] write_back_o_reg_rd;
  logic [XLEN-1:0]   write_back_o_reg_data;
`ifdef WB_INSTRET_EN
  logic [63:0]       write_back_o_instret;
`endif

  modport master (
    output regW_i_stall, regW_i_bubble,
    output memory_i_valid, memory_i_pc,
    output memory_i_valE, memory_i_valM,
    output memory_i_wb_rd, memory_i_wb_reg_wen,
    output memory_i_wb_valD_sel,
    output memory_i_load_func3,
    input  regW_o_valid, regW_o_pc,
    input  regW_o_valE, regW_o_valM,
    input  regW_o_wb_rd, regW_o_wb_reg_wen,
    input  regW_o_wb_valD_sel,
    input  write_back_o_reg_wen,
    input  write_back_o_reg_rd,
`ifdef WB_INSTRET_EN
    input  write_back_o_instret,
`endif
    input  write_back_o_reg_data
  );

  modport slave (
    input  regW_i_stall, regW_i_bubble,
    input  memory_i_valid, memory_i_pc,
    input  memory_i_valE, memory_i_valM,
    input  memory_i_wb_rd, memory_i_wb_reg_wen,
    input  memory_i_wb_valD_sel,
    input  memory_i_load_func3,
    output regW_o_valid, regW_o_pc,
    output regW_o_valE, regW_o_valM,
    output regW_o_wb_rd, regW_o_wb_reg_wen,
    output regW_o_wb_valD_sel,
    output write_back_o_reg_wen,
    output write_back_o_reg_rd,
`ifdef WB_INSTRET_EN
    output write_back_o_instret,
`endif
    output write_back_o_reg_data
  );
endinterface

// File: rtl/load_extend.sv
// Lane select and sign/zero extension of an aligned load doubleword.
// Misaligned low offset bits are dropped by rounding the lane down.
module load_extend
  import pipeline_defs::*;
(
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  always_comb begin
    b = raw_i[{off_i, 3'b000} +: 8];
    h = raw_i[{off_i[2:1], 4'b0000} +: 16];
    w = raw_i[{off_i[2], 5'b00000} +: 32];
    data_o = raw_i;
    unique case (func3_i)
      F3_LB:   data_o = {{56{b[7]}}, b};
      F3_LBU:  data_o = {56'd0, b};
      F3_LH:   data_o = {{48{h[15]}}, h};
      F3_LHU:  data_o = {48'd0, h};
      F3_LW:   data_o = {{32{w[31]}}, w};
      F3_LWU:  data_o = {32'd0, w};
      default: data_o = raw_i;
    endcase
  end
endmodule

// File: rtl/write_back_stage.sv
// W pipeline register and regfile write port of the RV64I pipeline.
// Define WB_INSTRET_EN to add the retired-instruction counter.
module write_back_stage
  import pipeline_defs::*;
(
  input  logic clk,
  input  logic rst,
  write_back_stage_if.slave wb
);
  w_reg_t          w_q, w_d;
  logic [XLEN-1:0] valM_ext;
  logic [XLEN-1:0] data;

  always_comb begin
    w_d = w_q;
    if (wb.regW_i_bubble) begin
      w_d = W_NOP;
    end else if (!wb.regW_i_stall) begin
      w_d.valid = wb.memory_i_valid;
      w_d.pc    = wb.memory_i_pc;
      w_d.valE  = wb.memory_i_valE;
      w_d.valM  = wb.memory_i_valM;
      w_d.rd    = wb.memory_i_wb_rd;
      w_d.wen   = wb.memory_i_wb_reg_wen;
      w_d.sel   = wb.memory_i_wb_valD_sel;
      w_d.func3 = wb.memory_i_load_func3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_q <= W_NOP;
    else     w_q <= w_d;
  end

  load_extend u_ext (
    .raw_i   (w_q.valM),
    .off_i   (w_q.valE[2:0]),
    .func3_i (w_q.func3),
    .data_o  (valM_ext)
  );

  always_comb begin
    data = '0;
    unique case (w_q.sel)
      WB_SEL_VALE: data = w_q.valE;
      WB_SEL_VALM: data = valM_ext;
      WB_SEL_VALP: data = w_q.pc + 64'd4;
      default:     data = '0;
    endcase
  end

  assign wb.regW_o_valid       = w_q.valid;
  assign wb.regW_o_pc          = w_q.pc;
  assign wb.regW_o_valE        = w_q.valE;
  assign wb.regW_o_valM        = valM_ext;
  assign wb.regW_o_wb_rd       = w_q.rd;
  assign wb.regW_o_wb_reg_wen  = w_q.wen;
  assign wb.regW_o_wb_valD_sel = w_q.sel;

  // x0 is hard-wired zero, so a write to it is suppressed here
  assign wb.write_back_o_reg_wen  = w_q.valid & w_q.wen & (|w_q.rd);
  assign wb.write_back_o_reg_rd   = w_q.rd;
  assign wb.write_back_o_reg_data = data;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;
  logic        retire;

  assign retire    = w_q.valid & (wb.regW_i_bubble | ~wb.regW_i_stall);
  assign instret_d = instret_q + {63'd0, retire};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign wb.write_back_o_instret = instret_q;
`endif
endmodule

// File: tb/tb_write_back_stage.sv
// Directed scoreboard bench for write_back_stage.
// Instret checks are compiled in when WB_INSTRET_EN is defined.
module tb_write_back_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  write_back_stage_if wif ();

  write_back_stage dut (
    .clk (clk),
    .rst (rst),
    .wb  (wif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic drv(input logic v, input logic [63:0] pc,
                     input logic [63:0] ve, input logic [63:0] vm,
                     input logic [4:0] rd, input logic wen,
                     input logic [1:0] sel, input logic [2:0] f3);
    wif.regW_i_stall         = 1'b0;
    wif.regW_i_bubble        = 1'b0;
    wif.memory_i_valid       = v;
    wif.memory_i_pc          = pc;
    wif.memory_i_valE        = ve;
    wif.memory_i_valM        = vm;
    wif.memory_i_wb_rd       = rd;
    wif.memory_i_wb_reg_wen  = wen;
    wif.memory_i_wb_valD_sel = sel;
    wif.memory_i_load_func3  = f3;
  endtask

  task automatic expect_wb(input string tag, input logic v,
                           input logic wen, input logic [4:0] rd,
                           input logic [63:0] data);
    exp_t e;
    e.valid = v;
    e.wen   = wen;
    e.rd    = rd;
    e.data  = data;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic tick_check();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".valid"}, 64'(wif.regW_o_valid), 64'(e.valid));
    chk({t, ".wen"}, 64'(wif.write_back_o_reg_wen), 64'(e.wen));
    chk({t, ".rd"}, 64'(wif.write_back_o_reg_rd), 64'(e.rd));
    chk({t, ".data"}, wif.write_back_o_reg_data, e.data);
  endtask

  localparam logic [63:0] LD = 64'h8877_6655_4433_2281;

  initial begin
    wif.regW_i_stall         = 1'($urandom);
    wif.regW_i_bubble        = 1'($urandom);
    wif.memory_i_valid       = 1'b1;
    wif.memory_i_pc          = {$urandom, $urandom};
    wif.memory_i_valE        = {$urandom, $urandom};
    wif.memory_i_valM        = {$urandom, $urandom};
    wif.memory_i_wb_rd       = 5'($urandom_range(1, 31));
    wif.memory_i_wb_reg_wen  = 1'b1;
    wif.memory_i_wb_valD_sel = 2'($urandom);
    wif.memory_i_load_func3  = 3'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 64'(wif.regW_o_valid), 64'd0);
    chk("rst.pc", wif.regW_o_pc, 64'd0);
    chk("rst.valE", wif.regW_o_valE, 64'd0);
    chk("rst.valM", wif.regW_o_valM, 64'd0);
    chk("rst.rd", 64'(wif.regW_o_wb_rd), 64'd0);
    chk("rst.regwen", 64'(wif.regW_o_wb_reg_wen), 64'd0);
    chk("rst.sel", 64'(wif.regW_o_wb_valD_sel), 64'd0);
    chk("rst.wen", 64'(wif.write_back_o_reg_wen), 64'd0);
    chk("rst.data", wif.write_back_o_reg_data, 64'd0);
`ifdef WB_INSTRET_EN
    chk("rst.instret", wif.write_back_o_instret, 64'd0);
`endif
    rst = 1'b0;

    drv(1, 64'h100, 64'h1234, 64'h0, 5, 1, 2'b00, 3'b000);
    expect_wb("add", 1, 1, 5, 64'h1234);
    tick_check();
    chk("add.valE", wif.regW_o_valE, 64'h1234);
    chk("add.pc", wif.regW_o_pc, 64'h100);

    drv(1, 64'h104, 64'h1000, LD, 10, 1, 2'b01, 3'b000);
    expect_wb("lb0", 1, 1, 10, 64'hFFFF_FFFF_FFFF_FF81);
    tick_check();
    chk("lb0.valM", wif.regW_o_valM, 64'hFFFF_FFFF_FFFF_FF81);
    drv(1, 64'h108, 64'h1007, LD, 11, 1, 2'b01, 3'b100);
    expect_wb("lbu7", 1, 1, 11, 64'h88);
    tick_check();
    drv(1, 64'h10C, 64'h1001, LD, 12, 1, 2'b01, 3'b000);
    expect_wb("lb1", 1, 1, 12, 64'h22);
    tick_check();
    drv(1, 64'h110, 64'h1002, LD, 13, 1, 2'b01, 3'b001);
    expect_wb("lh2", 1, 1, 13, 64'h4433);
    tick_check();
    drv(1, 64'h114, 64'h1003, LD, 13, 1, 2'b01, 3'b001);
    expect_wb("lh3mis", 1, 1, 13, 64'h4433);
    tick_check();
    drv(1, 64'h118, 64'h1006, LD, 14, 1, 2'b01, 3'b101);
    expect_wb("lhu6", 1, 1, 14, 64'h8877);
    tick_check();
    drv(1, 64'h11C, 64'h1006, LD, 14, 1, 2'b01, 3'b001);
    expect_wb("lh6", 1, 1, 14, 64'hFFFF_FFFF_FFFF_8877);
    tick_check();
    drv(1, 64'h120, 64'h1004, LD, 15, 1, 2'b01, 3'b110);
    expect_wb("lwu4", 1, 1, 15, 64'h8877_6655);
    tick_check();
    drv(1, 64'h124, 64'h1004, LD, 16, 1, 2'b01, 3'b010);
    expect_wb("lw4", 1, 1, 16, 64'hFFFF_FFFF_8877_6655);
    tick_check();
    drv(1, 64'h128, 64'h1000, LD, 17, 1, 2'b01, 3'b010);
    expect_wb("lw0", 1, 1, 17, 64'h4433_2281);
    tick_check();
    drv(1, 64'h12C, 64'h1000, LD, 18, 1, 2'b01, 3'b011);
    expect_wb("ld", 1, 1, 18, LD);
    tick_check();

    drv(1, 64'h8000_0000, 64'h55, 64'h0, 1, 1, 2'b10, 3'b000);
    expect_wb("jal", 1, 1, 1, 64'h8000_0004);
    tick_check();
    drv(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h55, 64'h0, 1, 1, 2'b10, 3'b000);
    expect_wb("jalwrap", 1, 1, 1, 64'h0);
    tick_check();
    drv(1, 64'h200, 64'h55, LD, 2, 1, 2'b11, 3'b011);
    expect_wb("selrsv", 1, 1, 2, 64'h0);
    tick_check();
    drv(1, 64'h204, 64'h7, 64'h0, 0, 1, 2'b00, 3'b000);
    expect_wb("x0", 1, 0, 0, 64'h7);
    tick_check();
    drv(0, 64'h208, 64'h9, 64'h0, 3, 1, 2'b00, 3'b000);
    expect_wb("inval", 0, 0, 3, 64'h9);
    tick_check();
    drv(1, 64'h20C, 64'hA, 64'h0, 4, 0, 2'b00, 3'b000);
    expect_wb("nowen", 1, 0, 4, 64'hA);
    tick_check();

    drv(1, 64'h300, 64'hABCD, 64'h0, 7, 1, 2'b00, 3'b000);
    expect_wb("pre_stall", 1, 1, 7, 64'hABCD);
    tick_check();
    for (int i = 0; i < 3; i++) begin
      drv(1, 64'h400, 64'h1111, 64'h0, 9, 1, 2'b00, 3'b000);
      wif.regW_i_stall = 1'b1;
      expect_wb($sformatf("stall%0d", i), 1, 1, 7, 64'hABCD);
      tick_check();
      chk($sformatf("stall%0d.pc", i), wif.regW_o_pc, 64'h300);
    end
    wif.regW_i_bubble = 1'b1;
    expect_wb("stallbub", 0, 0, 0, 64'h0);
    tick_check();
    chk("stallbub.pc", wif.regW_o_pc, 64'h0);

`ifdef WB_INSTRET_EN
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("ir.start", wif.write_back_o_instret, 64'd0);
    for (int i = 0; i < 10; i++) begin
      drv(1, 64'h500 + 64'(i * 4), 64'(i), 64'h0, 6, 1, 2'b00, 3'b000);
      if (i == 5) begin
        wif.regW_i_stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wif.regW_i_stall = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("ir.mid", wif.write_back_o_instret, 64'd9);
    wif.regW_i_bubble = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ir.final", wif.write_back_o_instret, 64'd10);
    drv(1, 64'h600, 64'h1, 64'h0, 6, 1, 2'b00, 3'b000);
    repeat (2) @(posedge clk);
    #1;
`else
    drv(1, 64'h600, 64'h1, 64'h0, 6, 1, 2'b00, 3'b000);
    @(posedge clk);
    #1;
`endif
    chk("pre_arst.valid", 64'(wif.regW_o_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid", 64'(wif.regW_o_valid), 64'd0);
    chk("arst.wen", 64'(wif.write_back_o_reg_wen), 64'd0);
    chk("arst.data", wif.write_back_o_reg_data, 64'd0);
`ifdef WB_INSTRET_EN
    chk("arst.instret", wif.write_back_o_instret, 64'd0);
`endif
    chk("sb.empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/write_back_stage.md
# write_back_stage

W-stage pipeline register plus write-back datapath of the RV64I five-stage pipeline: the writer side of the register file read by decode. It captures the M-stage result each cycle, extracts and sign/zero-extends load data, selects the write-back value (valE / valM / pc+4), and drives the register-file write port. Its registered fields also feed decode's W-stage forwarding.

## Interface
- `XLEN`, 64: datapath width.
- `REG_AW`, 5: register index width.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `regW_i_stall`, in, 1: hold W register contents.
- `regW_i_bubble`, in, 1: load a NOP into W; overrides stall.
- `memory_i_valid`, in, 1: M stage holds a real instruction.
- `memory_i_pc`, in, XLEN: PC of the M-stage instruction.
- `memory_i_valE`, in, XLEN: ALU result; for loads, the byte address.
- `memory_i_valM`, in, XLEN: raw aligned doubleword from data memory.
- `memory_i_wb_rd`, in, REG_AW: destination register.
- `memory_i_wb_reg_wen`, in, 1: instruction writes rd.
- `memory_i_wb_valD_sel`, in, 2: write-back source select.
- `memory_i_load_func3`, in, 3: load func3; don't-care unless sel = valM.
- `regW_o_valid`, `regW_o_pc`, `regW_o_valE`, `regW_o_wb_rd`, `regW_o_wb_reg_wen`, `regW_o_wb_valD_sel`, out: registered W fields, same widths as inputs.
- `regW_o_valM`, out, XLEN: extended load data (registered raw data passed through `load_extend`).
- `write_back_o_reg_wen`, out, 1: regfile write enable.
- `write_back_o_reg_rd`, out, REG_AW: regfile write index.
- `write_back_o_reg_data`, out, XLEN: regfile write data.
- `write_back_o_instret`, out, 64: retired-instruction count. Present only with `WB_INSTRET_EN`.

## Operation
- W register update on each rising edge:
  - bubble=1: load NOP. valid=0, wen=0, rd=0, all other fields 0.
  - else stall=1: hold.
  - else: capture all `memory_i_*` fields, including raw valM and func3.
- Write-back select:
  - 2'b00 = valE.
  - 2'b01 = valM (extended).
  - 2'b10 = valP = pc+4, mod 2^64.
  - 2'b11 = reserved, data 0.
- Load extension, using offset a = valE[2:0]:
  - 000 lb: sign-extend byte a.
  - 100 lbu: zero-extend byte a.
  - 001 lh: sign-extend halfword at a[2:1].
  - 101 lhu: zero-extend halfword at a[2:1].
  - 010 lw: sign-extend word at a[2].
  - 110 lwu: zero-extend word at a[2].
  - 011 ld and 111: raw doubleword.
  - Misaligned low bits are ignored (lane rounded down). No trap.
- Write port:
  - wen = regW_o_valid & regW_o_wb_reg_wen & (rd != 0).
  - rd and data are driven from W fields regardless of wen.
- x0 is never written. rd=0 with wen=1 produces wen_out=0.

## Timing
- Reset: every registered output is 0, valid=0, write_back_o_reg_wen=0, instret=0. Reset is asynchronous and takes effect mid-cycle, discarding any in-flight W instruction.
- Latency: M inputs at edge N appear on regW_o_* and the write port in cycle N+1. The regfile commits at edge N+2.
- Write port is combinational from W registers; no extra cycle.
- Stall: W held. The same write is re-presented every stalled cycle, which is idempotent.
- bubble and stall both high: bubble wins.
- pc = 0xFFFF_FFFF_FFFF_FFFC with sel=valP: data = 0.

## Configuration
- `WB_INSTRET_EN` defined: 64-bit counter `write_back_o_instret`.
  - Increments on each rising edge where regW_o_valid & (regW_i_bubble | ~regW_i_stall), i.e. a valid instruction leaves W.
  - Wraps at 2^64.
  - Reset to 0.
- Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `pipeline_defs`: wb_valD_sel encodings (`WB_SEL_VALE`, `WB_SEL_VALM`, `WB_SEL_VALP`), load func3 constants, XLEN/REG_AW. Decode uses the same package.
- One combinational sub-module, `load_extend`, with inputs raw doubleword, offset[2:0] and func3, and output XLEN extended data.

## Test plan
- Reset with random inputs held: all outputs 0. Release, capture add: valE=0x1234, rd=5, sel=valE → next cycle wen=1, rd=5, data=0x1234.
- Load extension on valM=0x8877_6655_4433_2281:
  - lb, a=0 → 0xFFFF_FFFF_FFFF_FF81.
  - lbu, a=7 → 0x88.
  - lh, a=2 → 0x4433.
  - lwu, a=4 → 0x8877_6655.
  - lw, a=4 → 0xFFFF_FFFF_8877_6655.
- jal: pc=0x8000_0000, sel=valP, rd=1 → data=0x8000_0004. Repeat with pc=0xFFFF_FFFF_FFFF_FFFC → data=0.
- rd=0 with wen=1 → write_back_o_reg_wen=0. valid=0 with wen=1 → wen_out=0.
- Stall for 3 cycles: W fields and write port unchanged. Stall+bubble together → valid=0, wen=0 next cycle.
- With `WB_INSTRET_EN`: 10 valid instructions, 3 stall cycles, 2 bubbles → instret=10. Async reset asserted mid-cycle → instret=0 immediately.
